// File: rtl/lcd_pkg.sv
// Shared types and default timing for the LCD bus receiver: captured word
// format, HD44780 command codes and the busy-emulation state encoding.
package lcd_pkg;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_word_t;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  // Panel timing expressed in 50 MHz clock cycles.
  localparam int LCD_MIN_E_HIGH  = 12;
  localparam int LCD_CMD_CYCLES  = 2000;
  localparam int LCD_DATA_CYCLES = 2150;
  localparam int LCD_LONG_CYCLES = 82000;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } busy_state_t;

  // Clear (0x01) and return-home (0x02/0x03) take the long execution time.
  function automatic logic is_long_cmd(input logic [7:0] code);
    return (code == LCD_CMD_CLEAR) || (code[7:1] == LCD_CMD_HOME[7:1]);
  endfunction

endpackage

// File: rtl/lcd_word_fifo.sv
// Small synchronous FIFO of captured bus words; accepts a push into a full
// FIFO when a pop happens in the same cycle, and holds the last head when empty.
module lcd_word_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic [8:0] push_word,
  input  logic       pop,
  output logic [8:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  lcd_word_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [8:0]      last_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? last_q : mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count need one,
  // since a word is never read before it has been written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Receiving end of the HD44780-style write bus: synchronises RS/E/D, captures
// each write on the E falling edge, emulates panel busy time and flags misuse.
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int MIN_E_HIGH  = LCD_MIN_E_HIGH,
  parameter int CMD_CYCLES  = LCD_CMD_CYCLES,
  parameter int DATA_CYCLES = LCD_DATA_CYCLES,
  parameter int LONG_CYCLES = LCD_LONG_CYCLES
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rs,
  input  logic       e,
  input  logic [7:0] d,
  output logic [8:0] word_out,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       busy,
  output logic       violation,
  output logic       overflow,
  input  logic       clear_flags
);

  localparam int MAX_A  = (CMD_CYCLES > DATA_CYCLES) ? CMD_CYCLES : DATA_CYCLES;
  localparam int MAX_N  = (MAX_A > LONG_CYCLES) ? MAX_A : LONG_CYCLES;
  localparam int CW     = $clog2(MAX_N + 1);
  localparam int WW     = $clog2(MIN_E_HIGH + 1);

  logic [9:0]    bus_s1;
  logic [9:0]    bus_s2;
  logic          e_prev;
  logic          e_s2;
  logic          e_fall;
  logic [WW-1:0] e_width;
  logic          short_pulse;
  logic          accept;
  lcd_word_t     cap_word;
  logic [CW-1:0] load_cycles;
  logic [CW-1:0] busy_cnt;
  busy_state_t   state_q;
  busy_state_t   state_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes the chain a chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_s1 <= '0;
      bus_s2 <= '0;
      e_prev <= 1'b0;
    end else begin
      bus_s1 <= {e, rs, d};
      bus_s2 <= bus_s1;
      e_prev <= bus_s2[9];
    end
  end

  assign e_s2           = bus_s2[9];
  assign cap_word.rs    = bus_s2[8];
  assign cap_word.data  = bus_s2[7:0];
  assign e_fall         = e_prev & ~e_s2;
  assign short_pulse    = e_fall & (e_width < WW'(MIN_E_HIGH));
  assign accept         = e_fall & ~short_pulse;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     e_width <= '0;
    else if (e_fall)                  e_width <= '0;
    else if (e_s2 && e_width != '1)   e_width <= e_width + 1'b1;
  end

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    load_cycles = CW'(CMD_CYCLES);
    if (cap_word.rs)                     load_cycles = CW'(DATA_CYCLES);
    else if (is_long_cmd(cap_word.data)) load_cycles = CW'(LONG_CYCLES);
  end

  // Busy emulation: state register, next-state logic, output decode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (!accept && busy_cnt == CW'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_BUSY);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            busy_cnt <= '0;
    else if (accept)         busy_cnt <= load_cycles;
    else if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
  end

  assign word_valid = ~fifo_empty;
  assign pop        = word_valid & word_ready;

  lcd_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (accept),
    .push_word (cap_word),
    .pop       (pop),
    .head      (word_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A set event in the same cycle as clear_flags leaves the flag set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      violation <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      violation <= short_pulse | (accept & busy) | (violation & ~clear_flags);
      overflow  <= (accept & fifo_full & ~pop) | (overflow & ~clear_flags);
    end
  end

endmodule
